// File: rtl/synth_pkg.sv
// Shared WaveGen / PWM sink definitions: sample width, full-scale value and sample type.
package synth_pkg;

  localparam int WAVE_DEPTH = 8;

  typedef logic [WAVE_DEPTH-1:0] wave_t;

  localparam wave_t WAVE_MAX = '1;

endpackage

// File: rtl/pwm_dac_out_if.sv
// Sample stream handshake between the waveform generator (master) and the PWM sink (slave).
interface pwm_dac_out_if;

  synth_pkg::wave_t sample;
  logic             sample_valid;
  logic             sample_ready;

  modport master (output sample, output sample_valid, input sample_ready);
  modport slave  (input sample, input sample_valid, output sample_ready);

endinterface

// File: rtl/pwm_tick_gen.sv
// Prescale counter: tick is high on the last clock of every PRESCALE-clock period.
module pwm_tick_gen #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] tick_cnt_q, tick_cnt_d;

  always_comb begin
    tick       = (tick_cnt_q == LAST);
    tick_cnt_d = tick ? '0 : tick_cnt_q + CW'(1);
  end

  // NOTE: sequential state is updated with <= only; blocking assignments here would race with readers.
  always_ff @(posedge clk) begin
    if (rst) tick_cnt_q <= '0;
    else     tick_cnt_q <= tick_cnt_d;
  end

endmodule

// File: rtl/pwm_dac_out.sv
// PWM audio sink: one-entry sample hold buffer, duty updated only at frame boundaries.
// Optional saturating underrun counter built when PWM_UNDERRUN_CNT_EN is defined.
module pwm_dac_out
  import synth_pkg::*;
#(
  parameter int unsigned PRESCALE = 1
) (
  input  logic               clk,
  input  logic               rst,
  pwm_dac_out_if.slave       s_if,
  output logic               pwm_out,
  output logic               frame_start,
  output logic               underrun
`ifdef PWM_UNDERRUN_CNT_EN
  ,
  output logic [15:0]        underrun_count
`endif
);

  logic  tick;
  logic  boundary;
  logic  accept;

  wave_t pwm_cnt_q,     pwm_cnt_d;
  wave_t active_q,      active_d;
  wave_t hold_q,        hold_d;
  logic  hold_full_q,   hold_full_d;
  logic  pwm_out_q,     pwm_out_d;
  logic  frame_start_q, frame_start_d;
  logic  underrun_q,    underrun_d;

  pwm_tick_gen #(.PRESCALE(PRESCALE)) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    accept        = s_if.sample_valid && !hold_full_q;
    boundary      = tick && (pwm_cnt_q == WAVE_MAX);

    pwm_cnt_d     = tick ? pwm_cnt_q + wave_t'(1) : pwm_cnt_q;
    active_d      = active_q;
    hold_d        = hold_q;
    hold_full_d   = hold_full_q;

    // A full buffer cannot accept, so transfer and accept never compete for hold.
    if (boundary && hold_full_q) begin
      active_d    = hold_q;
      hold_full_d = 1'b0;
    end else if (accept) begin
      hold_d      = s_if.sample;
      hold_full_d = 1'b1;
    end

    pwm_out_d     = (pwm_cnt_q < active_q);
    frame_start_d = boundary;
    underrun_d    = boundary && !hold_full_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt_q     <= '0;
      active_q      <= '0;
      hold_full_q   <= 1'b0;
      pwm_out_q     <= 1'b0;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      pwm_cnt_q     <= pwm_cnt_d;
      active_q      <= active_d;
      hold_full_q   <= hold_full_d;
      pwm_out_q     <= pwm_out_d;
      frame_start_q <= frame_start_d;
      underrun_q    <= underrun_d;
    end
  end

  // NOTE: the hold data register needs no reset; hold_full_q gates every use of it.
  always_ff @(posedge clk) begin
    hold_q <= hold_d;
  end

`ifdef PWM_UNDERRUN_CNT_EN
  logic [15:0] underrun_count_q, underrun_count_d;

  always_comb begin
    underrun_count_d = underrun_count_q;
    if (underrun_d && (underrun_count_q != 16'hFFFF))
      underrun_count_d = underrun_count_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) underrun_count_q <= '0;
    else     underrun_count_q <= underrun_count_d;
  end

  assign underrun_count = underrun_count_q;
`endif

  assign s_if.sample_ready = !hold_full_q;
  assign pwm_out           = pwm_out_q;
  assign frame_start       = frame_start_q;
  assign underrun          = underrun_q;

endmodule

// File: tb/tb_pwm_dac_out.sv
// Directed bench for pwm_dac_out: DUT a runs PRESCALE=1, DUT b runs PRESCALE=4.
module tb_pwm_dac_out;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  logic pwm_out_a, frame_start_a, underrun_a;
  logic pwm_out_b, frame_start_b, underrun_b;
  logic [15:0] ucnt_a, ucnt_b;

  int pass_cnt = 0;
  int total    = 0;

  pwm_dac_out_if if_a ();
  pwm_dac_out_if if_b ();

  always #5 clk = ~clk;

  pwm_dac_out #(.PRESCALE(1)) dut_a (
    .clk            (clk),
    .rst            (rst_a),
    .s_if           (if_a),
    .pwm_out        (pwm_out_a),
    .frame_start    (frame_start_a),
    .underrun       (underrun_a)
`ifdef PWM_UNDERRUN_CNT_EN
    ,
    .underrun_count (ucnt_a)
`endif
  );

  pwm_dac_out #(.PRESCALE(4)) dut_b (
    .clk            (clk),
    .rst            (rst_b),
    .s_if           (if_b),
    .pwm_out        (pwm_out_b),
    .frame_start    (frame_start_b),
    .underrun       (underrun_b)
`ifdef PWM_UNDERRUN_CNT_EN
    ,
    .underrun_count (ucnt_b)
`endif
  );

  typedef struct {
    logic [7:0] sample;
    int         exp_highs;
  } duty_vec_t;

  duty_vec_t vecs [5];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    total++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Present a sample on DUT a until one edge sees ready; valid drops afterwards.
  task automatic send_a(input logic [7:0] v, output logic ok);
    logic r;
    ok = 1'b0;
    if_a.sample       = v;
    if_a.sample_valid = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      r = if_a.sample_ready;
      step();
      if (r) begin
        ok = 1'b1;
        break;
      end
    end
    if_a.sample_valid = 1'b0;
  endtask

  task automatic wait_frame_a(output int urs, output logic ok);
    urs = 0;
    ok  = 1'b0;
    for (int i = 0; i < 300; i++) begin
      step();
      urs += int'(underrun_a);
      if (frame_start_a) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Called on a frame-start cycle; covers the 256 PwmOut samples that belong to that frame.
  task automatic measure_a(output int highs, output int fs_mid, output logic fs_end, output logic ur_end);
    highs  = 0;
    fs_mid = 0;
    for (int j = 1; j <= 256; j++) begin
      step();
      highs += int'(pwm_out_a);
      if (j < 256) fs_mid += int'(frame_start_a);
    end
    fs_end = frame_start_a;
    ur_end = underrun_a;
  endtask

  initial begin
    int   highs, fs_mid, urs, n, rdy_hi, ur_sum;
    logic fs_end, ur_end, ok, r;

    vecs[0] = '{8'h01, 1};
    vecs[1] = '{8'h40, 64};
    vecs[2] = '{8'hC0, 192};
    vecs[3] = '{8'hFF, 255};
    vecs[4] = '{8'h7F, 127};

    rst_a = 1'b1;
    rst_b = 1'b1;
    if_a.sample = '0; if_a.sample_valid = 1'b0;
    if_b.sample = '0; if_b.sample_valid = 1'b0;
    repeat (3) step();
    rst_a = 1'b0;

    // Test 1: reset values, single sample 0x40
    check("reset_pwm_out", pwm_out_a, 0);
    check("reset_frame_start", frame_start_a, 0);
    check("reset_underrun", underrun_a, 0);
    check("reset_ready", if_a.sample_ready, 1);
`ifdef PWM_UNDERRUN_CNT_EN
    check("reset_ucnt", ucnt_a, 0);
`endif
    if_a.sample = 8'h40; if_a.sample_valid = 1'b1;
    step();
    if_a.sample_valid = 1'b0;
    n = 1; rdy_hi = 0;
    while (!frame_start_a && n < 300) begin
      rdy_hi += int'(if_a.sample_ready);
      step();
      n++;
    end
    check("t1_frame0_len", n, 256);
    check("t1_ready_low_in_frame0", rdy_hi, 0);
    check("t1_no_underrun_frame0", underrun_a, 0);
    check("t1_ready_back", if_a.sample_ready, 1);
    measure_a(highs, fs_mid, fs_end, ur_end);
    check("t1_frame1_highs", highs, 64);
    check("t1_frame1_no_mid_fs", fs_mid, 0);
    check("t1_frame1_fs_end", fs_end, 1);
    check("t1_frame1_underrun", ur_end, 1);

    // Test 2: stream 0x00 then 0xFF with valid held high
    ur_sum = 0;
    if_a.sample = 8'h00; if_a.sample_valid = 1'b1;
    step();
    if_a.sample = 8'hFF;
    wait_frame_a(urs, ok);
    check("t2_wait_ok", ok, 1);
    ur_sum += urs;
    measure_a(highs, fs_mid, fs_end, ur_end);
    check("t2_zero_highs", highs, 0);
    ur_sum += int'(ur_end);
    measure_a(highs, fs_mid, fs_end, ur_end);
    check("t2_ff_highs", highs, 255);
    ur_sum += int'(ur_end);
    check("t2_no_underrun", ur_sum, 0);

    // Test 3: one 0x80 then three starved frames
    send_a(8'h80, ok);
    check("t3_send_ok", ok, 1);
    wait_frame_a(urs, ok);
    check("t3_no_underrun_at_load", underrun_a, 0);
    for (int f = 0; f < 3; f++) begin
      measure_a(highs, fs_mid, fs_end, ur_end);
      check($sformatf("t3_frame%0d_highs", f), highs, 128);
      check($sformatf("t3_frame%0d_underrun", f), ur_end, 1);
    end

    // Test 4: valid raised exactly on the boundary cycle, hold empty
    repeat (255) step();
    if_a.sample = 8'h10; if_a.sample_valid = 1'b1;
    r = if_a.sample_ready;
    step();
    if_a.sample_valid = 1'b0;
    check("t4_ready_at_boundary", r, 1);
    check("t4_frame_start", frame_start_a, 1);
    check("t4_underrun", underrun_a, 1);
    check("t4_hold_full", if_a.sample_ready, 0);
    measure_a(highs, fs_mid, fs_end, ur_end);
    check("t4_old_duty_repeats", highs, 128);
    check("t4_no_underrun_next", ur_end, 0);
    measure_a(highs, fs_mid, fs_end, ur_end);
    check("t4_new_duty", highs, 16);

    // Duty table
    foreach (vecs[i]) begin
      send_a(vecs[i].sample, ok);
      check($sformatf("tab%0d_send_ok", i), ok, 1);
      wait_frame_a(urs, ok);
      check($sformatf("tab%0d_frame_ok", i), ok, 1);
      measure_a(highs, fs_mid, fs_end, ur_end);
      check($sformatf("tab%0d_highs_%02h", i, vecs[i].sample), highs, vecs[i].exp_highs);
    end

    // Test 5: reset mid-frame with Active=0xC0 and hold full
    send_a(8'hC0, ok);
    wait_frame_a(urs, ok);
    send_a(8'h55, ok);
    check("t5_hold_full", if_a.sample_ready, 0);
    repeat (99) step();
    check("t5_pwm_high_before_reset", pwm_out_a, 1);
    rst_a = 1'b1;
    if_a.sample = 8'hAA; if_a.sample_valid = 1'b1;
    step();
    rst_a = 1'b0;
    if_a.sample_valid = 1'b0;
    check("t5_pwm_out", pwm_out_a, 0);
    check("t5_ready", if_a.sample_ready, 1);
    check("t5_frame_start", frame_start_a, 0);
    measure_a(highs, fs_mid, fs_end, ur_end);
    check("t5_frame0_highs", highs, 0);
    check("t5_frame0_no_mid_fs", fs_mid, 0);
    check("t5_frame0_fs_end", fs_end, 1);
    check("t5_frame0_underrun", ur_end, 1);
    measure_a(highs, fs_mid, fs_end, ur_end);
    check("t5_frame1_highs", highs, 0);
`ifdef PWM_UNDERRUN_CNT_EN
    check("t5_ucnt", ucnt_a, 2);
`endif

    // Test 6: PRESCALE=4, sample 0x02
    rst_b = 1'b0;
    check("t6_ready", if_b.sample_ready, 1);
    if_b.sample = 8'h02; if_b.sample_valid = 1'b1;
    step();
    if_b.sample_valid = 1'b0;
    n = 1;
    while (!frame_start_b && n < 1100) begin
      step();
      n++;
    end
    check("t6_frame0_len", n, 1024);
    check("t6_no_underrun_frame0", underrun_b, 0);
`ifdef PWM_UNDERRUN_CNT_EN
    check("t6_ucnt_zero", ucnt_b, 0);
`endif
    highs = 0; fs_mid = 0;
    for (int j = 1; j <= 1024; j++) begin
      step();
      highs += int'(pwm_out_b);
      if (j < 1024) fs_mid += int'(frame_start_b);
    end
    check("t6_highs", highs, 8);
    check("t6_no_mid_fs", fs_mid, 0);
    check("t6_fs_end", frame_start_b, 1);
    check("t6_underrun_end", underrun_b, 1);
    step();
    check("t6_underrun_one_clock", underrun_b, 0);
`ifdef PWM_UNDERRUN_CNT_EN
    check("t6_ucnt_one", ucnt_b, 1);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
